// File: rtl/version_pkg.sv
// rtl/version_pkg.sv - build identity constants consumed by version_reporter
// Purpose: version and BCD build timestamp of the loaded bitstream.
// Ports: none (package).
package version_pkg;

    localparam logic [7:0]  C_VERSION_MAJOR  = 8'h00;
    localparam logic [7:0]  C_VERSION_MINOR  = 8'h00;
    localparam logic [7:0]  C_VERSION_PATCH  = 8'h00;
    localparam logic [7:0]  C_VERSION_BUILD  = 8'h35;
    localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
    localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;
    localparam logic [7:0]  C_VERSION_DAY    = 8'h05;
    localparam logic [7:0]  C_VERSION_HOUR   = 8'h13;
    localparam logic [7:0]  C_VERSION_MINUTE = 8'h55;
    localparam logic [7:0]  C_VERSION_SECOND = 8'h09;

endpackage

// File: rtl/version_report_pkg.sv
// rtl/version_report_pkg.sv - frame constants, types and checksum for version_reporter
// Purpose: shared frame layout constants, FSM state type and the
//          elaboration-time checksum helper.
// Ports: none (package).
package version_report_pkg;

    localparam logic [7:0] C_VR_SYNC        = 8'hA5;
    localparam logic [7:0] C_VR_LEN         = 8'h0B;
    localparam int         C_VR_FRAME_BYTES = 14;

    typedef logic [3:0] vr_idx_t;

    localparam vr_idx_t C_VR_LAST_IDX = vr_idx_t'(C_VR_FRAME_BYTES - 1);

    typedef enum logic [1:0] {VR_IDLE, VR_SEND, VR_DONE} vr_state_t;

    // Two's complement of the byte sum over LEN..SECOND, so that bytes
    // 1..13 of the frame add up to zero modulo 256.
    function automatic logic [7:0] vr_checksum(
        input logic [7:0]  major,
        input logic [7:0]  minor,
        input logic [7:0]  patch,
        input logic [7:0]  build,
        input logic [15:0] year,
        input logic [7:0]  month,
        input logic [7:0]  day,
        input logic [7:0]  hour,
        input logic [7:0]  minute,
        input logic [7:0]  second
    );
        logic [7:0] sum;
        sum = C_VR_LEN + major + minor + patch + build + year[15:8] + year[7:0]
            + month + day + hour + minute + second;
        return 8'h00 - sum;
    endfunction

endpackage

// File: rtl/version_reporter_if.sv
// rtl/version_reporter_if.sv - byte stream bundle for the version frame output
// Purpose: groups the valid/ready byte stream between reporter and sink.
// Signals: tx_data (frame byte), tx_valid (byte valid), tx_ready (sink accepts).
interface version_reporter_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/version_frame_rom.sv
// rtl/version_frame_rom.sv - index to byte mapping of the version frame
// Purpose: purely combinational frame contents; checksum fixed at elaboration.
// Ports: idx_i (byte index 0..13), byte_o (frame byte at that index).
module version_frame_rom
    import version_report_pkg::*;
#(
    parameter logic [7:0]  G_MAJOR  = 8'h00,
    parameter logic [7:0]  G_MINOR  = 8'h00,
    parameter logic [7:0]  G_PATCH  = 8'h00,
    parameter logic [7:0]  G_BUILD  = 8'h00,
    parameter logic [15:0] G_YEAR   = 16'h0000,
    parameter logic [7:0]  G_MONTH  = 8'h00,
    parameter logic [7:0]  G_DAY    = 8'h00,
    parameter logic [7:0]  G_HOUR   = 8'h00,
    parameter logic [7:0]  G_MINUTE = 8'h00,
    parameter logic [7:0]  G_SECOND = 8'h00
) (
    input  vr_idx_t    idx_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] C_CHK = vr_checksum(G_MAJOR, G_MINOR, G_PATCH, G_BUILD, G_YEAR,
                                               G_MONTH, G_DAY, G_HOUR, G_MINUTE, G_SECOND);

    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            4'd0:    byte_o = C_VR_SYNC;
            4'd1:    byte_o = C_VR_LEN;
            4'd2:    byte_o = G_MAJOR;
            4'd3:    byte_o = G_MINOR;
            4'd4:    byte_o = G_PATCH;
            4'd5:    byte_o = G_BUILD;
            4'd6:    byte_o = G_YEAR[15:8];
            4'd7:    byte_o = G_YEAR[7:0];
            4'd8:    byte_o = G_MONTH;
            4'd9:    byte_o = G_DAY;
            4'd10:   byte_o = G_HOUR;
            4'd11:   byte_o = G_MINUTE;
            4'd12:   byte_o = G_SECOND;
            4'd13:   byte_o = C_CHK;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/version_reporter.sv
// rtl/version_reporter.sv - streams the build identity as a 14-byte frame
// Purpose: on request, sends SYNC, LEN, version, BCD timestamp and checksum
//          over a valid/ready byte stream; requests during a frame coalesce
//          into one follow-up frame.
// Ports: clk, rst_n (sync, active-low), req_i (report request),
//        tx_data_o/tx_valid_o/tx_ready_i (byte stream), busy_o (frame in
//        progress), done_o (pulse after last byte), frame_count_o (frames sent).
module version_reporter
    import version_report_pkg::*;
#(
    parameter logic [7:0]  G_MAJOR  = version_pkg::C_VERSION_MAJOR,
    parameter logic [7:0]  G_MINOR  = version_pkg::C_VERSION_MINOR,
    parameter logic [7:0]  G_PATCH  = version_pkg::C_VERSION_PATCH,
    parameter logic [7:0]  G_BUILD  = version_pkg::C_VERSION_BUILD,
    parameter logic [15:0] G_YEAR   = version_pkg::C_VERSION_YEAR,
    parameter logic [7:0]  G_MONTH  = version_pkg::C_VERSION_MONTH,
    parameter logic [7:0]  G_DAY    = version_pkg::C_VERSION_DAY,
    parameter logic [7:0]  G_HOUR   = version_pkg::C_VERSION_HOUR,
    parameter logic [7:0]  G_MINUTE = version_pkg::C_VERSION_MINUTE,
    parameter logic [7:0]  G_SECOND = version_pkg::C_VERSION_SECOND
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] frame_count_o
);

    vr_state_t   state_q, state_d;
    vr_idx_t     idx_q, idx_d;
    logic        pending_q, pending_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        done_q, done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        load_byte;
    logic [7:0]  rom_byte;
    logic        handshake;

    assign handshake = tx_valid_q & tx_ready_i;

    // The ROM is addressed by the next index so the output register can be
    // loaded with the byte that belongs to the index it will hold.
    version_frame_rom #(
        .G_MAJOR (G_MAJOR),  .G_MINOR (G_MINOR), .G_PATCH (G_PATCH),
        .G_BUILD (G_BUILD),  .G_YEAR  (G_YEAR),  .G_MONTH (G_MONTH),
        .G_DAY   (G_DAY),    .G_HOUR  (G_HOUR),  .G_MINUTE(G_MINUTE),
        .G_SECOND(G_SECOND)
    ) u_rom (
        .idx_i (idx_d),
        .byte_o(rom_byte)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        tx_valid_d    = tx_valid_q;
        done_d        = 1'b0;
        frame_count_d = frame_count_q;
        load_byte     = 1'b0;
        case (state_q)
            VR_IDLE: begin
                if (req_i) begin
                    state_d    = VR_SEND;
                    idx_d      = '0;
                    pending_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    load_byte  = 1'b1;
                end
            end
            VR_SEND: begin
                pending_d = pending_q | req_i;
                if (handshake) begin
                    if (idx_q == C_VR_LAST_IDX) begin
                        state_d       = VR_DONE;
                        tx_valid_d    = 1'b0;
                        done_d        = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        idx_d     = idx_q + vr_idx_t'(1);
                        load_byte = 1'b1;
                    end
                end
            end
            VR_DONE: begin
                // A request arriving in this very cycle counts as pending.
                if (pending_q || req_i) begin
                    state_d    = VR_SEND;
                    idx_d      = '0;
                    pending_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    load_byte  = 1'b1;
                end else begin
                    state_d = VR_IDLE;
                end
            end
            default: state_d = VR_IDLE;
        endcase
    end

    assign tx_data_d = load_byte ? rom_byte : tx_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= VR_IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            done_q        <= done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign done_o        = done_q;
    assign frame_count_o = frame_count_q;
    assign busy_o        = (state_q != VR_IDLE);

endmodule

// File: tb/tb_version_reporter.sv
// tb/tb_version_reporter.sv - self-checking bench for version_reporter
module tb_version_reporter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        busy, done;
    logic [15:0] count;
    logic        rnd_mode = 1'b0;

    logic        req2 = 1'b0;
    logic        ready2 = 1'b1;
    logic [7:0]  data2;
    logic        valid2, busy2, done2;
    logic [15:0] count2;

    int checks = 0;
    int errors = 0;

    // model state owned by the compare process
    int          cyc = 0;
    int          pos = 0;
    int          frames_done = 0;
    logic [15:0] mcount = 16'h0000;
    bit          exp_done = 0;
    bit          rst_pend = 0;
    bit          prev_v = 0;
    bit          prev_r = 0;
    logic [7:0]  prev_d = 8'h00;
    bit          have_chk = 0;
    int          chk_cyc = 0;
    int          gap = -1;
    bit          wrap_seen = 0;
    int          preset_seq = 0;
    int          preset_seen = 0;
    logic [15:0] preset_val = 16'h0000;

    logic [7:0]  gold [14];

    version_reporter_if tx_if ();

    version_reporter u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .tx_data_o    (tx_if.tx_data),
        .tx_valid_o   (tx_if.tx_valid),
        .tx_ready_i   (tx_if.tx_ready),
        .busy_o       (busy),
        .done_o       (done),
        .frame_count_o(count)
    );

    version_reporter #(.G_BUILD(8'hFF), .G_SECOND(8'h59)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req2),
        .tx_data_o    (data2),
        .tx_valid_o   (valid2),
        .tx_ready_i   (ready2),
        .busy_o       (busy2),
        .done_o       (done2),
        .frame_count_o(count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        tx_if.tx_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame contents derived from the field list with plain integer math.
    function automatic logic [7:0] model_byte(input int k, input int build, input int second);
        int f [14];
        int s;
        f = '{'hA5, 'h0B,
              int'(version_pkg::C_VERSION_MAJOR), int'(version_pkg::C_VERSION_MINOR),
              int'(version_pkg::C_VERSION_PATCH), build,
              int'(version_pkg::C_VERSION_YEAR) / 256, int'(version_pkg::C_VERSION_YEAR) % 256,
              int'(version_pkg::C_VERSION_MONTH), int'(version_pkg::C_VERSION_DAY),
              int'(version_pkg::C_VERSION_HOUR), int'(version_pkg::C_VERSION_MINUTE),
              second, 0};
        s = 0;
        for (int i = 1; i <= 12; i++) s += f[i];
        f[13] = (256 - (s % 256)) % 256;
        return 8'(f[k]);
    endfunction

    // Per-cycle compare against the stream model (sampled mid-cycle).
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rst_pend = 1;
            pos      = 0;
            exp_done = 0;
            mcount   = 16'h0000;
            prev_v   = 0;
            have_chk = 0;
        end else begin
            if (rst_pend) begin
                check("rst_valid", tx_if.tx_valid, 1'b0);
                check("rst_data", tx_if.tx_data, 8'h00);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_count", count, 16'h0000);
                rst_pend = 0;
            end
            if (preset_seq != preset_seen) begin
                mcount      = preset_val;
                preset_seen = preset_seq;
            end
            if (prev_v && !prev_r) begin
                check("hold_valid", tx_if.tx_valid, 1'b1);
                check("hold_data", tx_if.tx_data, prev_d);
            end
            if (exp_done) mcount = mcount + 16'd1;
            check("done", done, exp_done);
            check("count", count, mcount);
            if (exp_done) begin
                check("busy_done", busy, 1'b1);
                if (count == 16'h0000) wrap_seen = 1;
            end
            if (tx_if.tx_valid) begin
                check("stream_byte", tx_if.tx_data, model_byte(pos, int'(version_pkg::C_VERSION_BUILD),
                                                          int'(version_pkg::C_VERSION_SECOND)));
                check("busy_tx", busy, 1'b1);
                if (!prev_v && pos == 0 && have_chk) gap = cyc - chk_cyc;
            end
            exp_done = 0;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (pos == 13) begin
                    exp_done = 1;
                    chk_cyc  = cyc;
                    have_chk = 1;
                    pos      = 0;
                    frames_done++;
                end else begin
                    pos++;
                end
            end
            prev_v = tx_if.tx_valid;
            prev_r = tx_if.tx_ready;
            prev_d = tx_if.tx_data;
        end
    end

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, frames_done >= target, 1'b1);
    endtask

    task automatic pulse_req();
        @(posedge clk); #2 req = 1'b1;
        @(posedge clk); #2 req = 1'b0;
    endtask

    // Single request with ready held high: literal byte/latency expectations.
    task automatic run_single(input logic [15:0] exp_cnt);
        check("idle_busy", busy, 1'b0);
        pulse_req();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("single_valid", tx_if.tx_valid, 1'b1);
            check("single_byte", tx_if.tx_data, gold[k]);
        end
        @(negedge clk);
        check("single_done", done, 1'b1);
        check("single_count", count, exp_cnt);
        check("single_valid_off", tx_if.tx_valid, 1'b0);
        check("single_busy_done", busy, 1'b1);
        @(negedge clk);
        check("single_done_off", done, 1'b0);
        check("single_busy_off", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] got2 [14];
        int k, n, s, base;

        gold = '{8'hA5, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h35, 8'h20,
                 8'h25, 8'h11, 8'h05, 8'h13, 8'h55, 8'h09, 8'hF4};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_count", count, 16'h0000);
        check("reset_valid", tx_if.tx_valid, 1'b0);

        // single frame, ready always high
        run_single(16'h0001);

        // random backpressure
        rnd_mode = 1'b1;
        base = frames_done;
        pulse_req();
        wait_frames(base + 1, 3000, "bp_timeout");
        rnd_mode = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_count", count, 16'h0002);

        // three requests during frame 1 coalesce into one more frame
        base = frames_done;
        pulse_req();
        repeat (3) @(posedge clk);
        #2 req = 1'b1; @(posedge clk); #2 req = 1'b0;
        repeat (2) @(posedge clk);
        #2 req = 1'b1; @(posedge clk); #2 req = 1'b0;
        repeat (4) @(posedge clk);
        #2 req = 1'b1; @(posedge clk); #2 req = 1'b0;
        wait_frames(base + 2, 200, "coal_timeout");
        repeat (40) @(negedge clk);
        check("coal_frames", frames_done, base + 2);
        check("coal_count", count, 16'h0004);
        check("coal_gap", gap, 2);

        // parameter override instance
        @(posedge clk); #2 req2 = 1'b1;
        @(posedge clk); #2 req2 = 1'b0;
        k = 0;
        n = 0;
        while (k < 14 && n < 200) begin
            @(negedge clk);
            if (valid2) begin
                got2[k] = data2;
                k++;
            end
            n++;
        end
        check("ovr_len", k, 14);
        s = 0;
        for (int i = 0; i < 14; i++) begin
            check("ovr_byte", got2[i], model_byte(i, 'hFF, 'h59));
            if (i >= 1) s += got2[i];
        end
        check("ovr_build", got2[5], 8'hFF);
        check("ovr_second", got2[12], 8'h59);
        check("ovr_chk", got2[13], 8'hDA);
        check("ovr_sum", s % 256, 0);
        repeat (3) @(negedge clk);
        check("ovr_count", count2, 16'h0001);
        check("ovr_busy", busy2, 1'b0);

        // reset while byte index 6 is on the bus
        pulse_req();
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid_byte6", tx_if.tx_data, gold[6]);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", tx_if.tx_valid, 1'b0);
        check("mid_rst_data", tx_if.tx_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_count", count, 16'h0000);
        repeat (3) @(negedge clk);
        check("mid_no_resume", tx_if.tx_valid, 1'b0);
        run_single(16'h0001);

        // held request, counter preset near wrap
        @(posedge clk); #2 force u_dut.frame_count_q = 16'hFFFE;
        #1 release u_dut.frame_count_q;
        preset_val = 16'hFFFE;
        preset_seq++;
        @(negedge clk);
        check("preset_count", count, 16'hFFFE);
        base = frames_done;
        @(posedge clk); #2 req = 1'b1;
        repeat (40) @(posedge clk);
        #2 req = 1'b0;
        wait_frames(base + 4, 200, "hold_timeout");
        repeat (40) @(negedge clk);
        check("hold_frames", frames_done, base + 4);
        check("hold_count", count, 16'h0002);
        check("hold_wrap", wrap_seen, 1'b1);
        check("hold_gap", gap, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/version_reporter.md
# version_reporter

Streams the build's identity (version major/minor/patch/build and BCD build timestamp) as a fixed 14-byte frame over a valid/ready byte stream. The stream normally feeds the UART transmitter, so a host can query which bitstream is loaded. The block reads the auto-generated `version_pkg` constants, serialises them on request and frames them with a sync byte, a length byte and a checksum.

## Interface
Parameters (defaults come from `version_pkg` so a bench can override them):
- `G_MAJOR`, default `C_VERSION_MAJOR`: version major, 8 b.
- `G_MINOR`, default `C_VERSION_MINOR`: version minor, 8 b.
- `G_PATCH`, default `C_VERSION_PATCH`: version patch, 8 b.
- `G_BUILD`, default `C_VERSION_BUILD`: build number, 8 b.
- `G_YEAR`, default `C_VERSION_YEAR`: BCD year, 16 b.
- `G_MONTH`, `G_DAY`, `G_HOUR`, `G_MINUTE`, `G_SECOND`, defaults the matching `C_VERSION_*`: BCD fields, 8 b each.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_i` in 1: report request, sampled every cycle, level or pulse.
- `tx_data_o` out 8: current frame byte.
- `tx_valid_o` out 1: `tx_data_o` is valid.
- `tx_ready_i` in 1: sink accepts the byte on `tx_valid_o & tx_ready_i`.
- `busy_o` out 1: a frame is in progress (SEND or DONE state).
- `done_o` out 1: one-cycle pulse after the last byte is accepted.
- `frame_count_o` out 16: number of completed frames; wraps from 0xFFFF to 0.

## Operation
- Frame, index 0..13:
  - 0: SYNC 0xA5.
  - 1: LEN 0x0B.
  - 2–5: MAJOR, MINOR, PATCH, BUILD.
  - 6–7: YEAR[15:8], YEAR[7:0].
  - 8–12: MONTH, DAY, HOUR, MINUTE, SECOND.
  - 13: CHK = (0 − Σ bytes 1..12) mod 256, so bytes 1..13 sum to 0x00 mod 256.
- With the default constants the frame is A5 0B 00 00 00 35 20 25 11 05 13 55 09 F4.
- States:
  - IDLE → SEND when `req_i`=1 or `pending`=1. The byte index is cleared and `pending` is cleared.
  - SEND: the index advances on each handshake. On the handshake at index 13 → DONE.
  - DONE, one cycle: `done_o`=1, `frame_count_o` increments. → SEND if `pending`, else → IDLE.
- `pending` is a one-deep flag. It is set by `req_i`=1 in SEND or DONE. Any number of requests during one frame coalesce into exactly one further frame.
- A frame is never aborted or truncated except by reset.
- AXI-style hold rule: once `tx_valid_o` rises, `tx_data_o` and `tx_valid_o` are held stable until the handshake.
- `tx_valid_o` never depends combinationally on `tx_ready_i`.
- The checksum is computed at elaboration (constant function or package function), not in a runtime accumulator.

## Timing
- Reset values: `tx_data_o`=0x00, `tx_valid_o`=0, `busy_o`=0, `done_o`=0, `frame_count_o`=0. State is IDLE and `pending`=0.
- Reset in the middle of a frame: at the first edge with `rst_n`=0 all outputs take their reset values and the pending request is lost. After reset releases, the next frame starts at SYNC.
- Outputs are registered. `req_i` sampled high at edge N gives `tx_valid_o`=1 with SYNC from N+1.
- With `tx_ready_i` held at 1: one byte per cycle, bytes at cycles N+1..N+14, DONE at N+15, `busy_o` low from N+16.
- Back-to-back frames (`pending` set): the next SYNC is valid at N+16. There is exactly one idle cycle (DONE) between frames.
- When `tx_ready_i` is low, the index and `tx_data_o` hold indefinitely. There is no timeout.
- `req_i`=1 in the same cycle as DONE sets `pending`, and the next frame follows immediately.
- `busy_o` is 1 from the cycle after acceptance through DONE inclusive.

## Structure
- `version_report_pkg` holds:
  - `C_VR_SYNC` = 0xA5, `C_VR_LEN` = 0x0B, `C_VR_FRAME_BYTES` = 14.
  - `typedef logic [3:0] vr_idx_t`.
  - `typedef enum {VR_IDLE, VR_SEND, VR_DONE} vr_state_t`.
  - the checksum function.
- Sub-module `version_frame_rom`: combinational mapping from index to byte, with the fields as parameters. `version_reporter` contains the FSM, index counter, `pending` flag, output registers and frame counter.

## Test plan
- Defaults, `tx_ready_i`=1, single `req_i` pulse → bytes A5 0B 00 00 00 35 20 25 11 05 13 55 09 F4 on 14 consecutive cycles starting 1 cycle after the request. `done_o` pulses once; `frame_count_o`=1.
- Random `tx_ready_i` backpressure (about 30% ready) → identical byte sequence; data and valid stable while ready is low; no byte is skipped or duplicated.
- Three `req_i` pulses during frame 1 → exactly 2 frames. Second SYNC arrives exactly 2 cycles after frame 1's CHK handshake (with ready=1); `frame_count_o`=2.
- Bench overrides G_BUILD=0xFF and G_SECOND=0x59 → bytes 5 and 12 change and CHK keeps Σ(bytes 1..13) mod 256 = 0.
- `rst_n` driven low at byte index 6 → all outputs at reset values at the next edge. A new request after release yields a full frame from SYNC.
- `req_i` held high for 40 cycles with ready=1 → continuous frames separated by one DONE cycle; `frame_count_o` preset by force near 0xFFFF wraps to 0x0000.
